hlpte_recon: RTL and testbench

HLPTE_RECON -- requirements
Module: hlpte_recon

---
 rtl/hlpte_recon_pkg.sv | 48 ++++
 rtl/hlpte_itrans4.sv | 28 ++
 rtl/hlpte_recon.sv | 165 ++++++++++++++++
 tb/tb_hlpte_recon.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hlpte_recon_pkg.sv
// Shared types, constants and dequantization helper for the 4x4 inverse-transform reconstruction block.
package hlpte_recon_pkg;

    localparam int unsigned BLK_SIZE = 16;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned ACC_W    = 32;
    localparam int unsigned QP_W     = 5;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned V_W      = 5;
    localparam int unsigned RND      = 32;
    localparam int unsigned SHIFT    = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW,
        S_COL,
        S_OUT
    } state_e;

    // Rows: class a (both even), class b (both odd), class c (mixed); columns: QP%6.
    localparam logic [V_W-1:0] V_TAB [3][6] = '{
        '{5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18},
        '{5'd16, 5'd18, 5'd20, 5'd23, 5'd25, 5'd29},
        '{5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd23}
    };

    function automatic logic [1:0] coef_cls(input logic [1:0] row, input logic [1:0] col);
        if (!row[0] && !col[0]) return 2'd0;
        if (row[0] && col[0])   return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic signed [ACC_W-1:0] dequant(
        input logic signed [COEF_W-1:0] coef,
        input logic [1:0]               cls,
        input logic [2:0]               rem,
        input logic [2:0]               per
    );
        logic signed [ACC_W-1:0] scale;
        logic signed [ACC_W-1:0] prod;
        scale = $signed({{(ACC_W-V_W){1'b0}}, V_TAB[cls][rem]});
        prod  = ACC_W'(coef) * scale;
        return prod <<< per;
    endfunction

endpackage

// File: rtl/hlpte_itrans4.sv
// Combinational 4-point inverse-transform butterfly shared by the row and column passes.
module hlpte_itrans4
    import hlpte_recon_pkg::*;
(
    input  logic signed [ACC_W-1:0] d0,
    input  logic signed [ACC_W-1:0] d1,
    input  logic signed [ACC_W-1:0] d2,
    input  logic signed [ACC_W-1:0] d3,
    output logic signed [ACC_W-1:0] f0_c,
    output logic signed [ACC_W-1:0] f1_c,
    output logic signed [ACC_W-1:0] f2_c,
    output logic signed [ACC_W-1:0] f3_c
);

    logic signed [ACC_W-1:0] e0, e1, e2, e3;

    always_comb begin
        e0   = d0 + d2;
        e1   = d0 - d2;
        e2   = (d1 >>> 1) - d3;
        e3   = d1 + (d3 >>> 1);
        f0_c = e0 + e3;
        f1_c = e1 + e2;
        f2_c = e1 - e2;
        f3_c = e0 - e3;
    end

endmodule

// File: rtl/hlpte_recon.sv
// 4x4 block reconstruction: load coefficient/prediction pairs, dequantize, row then column
// inverse transform in place, then stream rounded residuals and clipped pixels in raster order.
module hlpte_recon
    import hlpte_recon_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic [PIX_W-1:0]         in_pred,
    input  logic [QP_W-1:0]          QP,
    output logic                     out_valid,
    output logic [PIX_W-1:0]         out_pixel,
    output logic signed [COEF_W-1:0] out_resid
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [2:0]              qp_per_q, qp_per_d;
    logic [2:0]              qp_rem_q, qp_rem_d;
    logic                    out_valid_q, out_valid_d;
    logic [PIX_W-1:0]        out_pixel_q, out_pixel_d;
    logic signed [COEF_W-1:0] out_resid_q, out_resid_d;

    logic signed [COEF_W-1:0] coef_q [BLK_SIZE];
    logic [PIX_W-1:0]         pred_q [BLK_SIZE];
    logic signed [ACC_W-1:0]  mat_q  [BLK_SIZE];

    logic                     accept_c;
    logic [1:0]               lane_c;
    logic signed [ACC_W-1:0]  bf_d_c [4];
    logic signed [ACC_W-1:0]  bf_f_c [4];
    logic signed [ACC_W-1:0]  rnd_c;
    logic signed [ACC_W-1:0]  pix_sum_c;
    logic signed [COEF_W-1:0] resid_c;
    logic [PIX_W-1:0]         pixel_c;

    assign accept_c = in_valid && (state_q == S_IDLE || state_q == S_LOAD);
    assign lane_c   = idx_q[1:0];

    // Butterfly operands: dequantized coefficient row in ROW, matrix column otherwise.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            bf_d_c[j] = '0;
            if (state_q == S_COL) begin
                bf_d_c[j] = mat_q[{2'(j), lane_c}];
            end else begin
                bf_d_c[j] = dequant(coef_q[{lane_c, 2'(j)}], coef_cls(lane_c, 2'(j)),
                                    qp_rem_q, qp_per_q);
            end
        end
    end

    hlpte_itrans4 u_itrans4 (
        .d0   (bf_d_c[0]),
        .d1   (bf_d_c[1]),
        .d2   (bf_d_c[2]),
        .d3   (bf_d_c[3]),
        .f0_c (bf_f_c[0]),
        .f1_c (bf_f_c[1]),
        .f2_c (bf_f_c[2]),
        .f3_c (bf_f_c[3])
    );

    // Rounding, residual truncation and pixel clip for the current raster index.
    always_comb begin
        rnd_c     = mat_q[idx_q] + $signed(ACC_W'(RND));
        resid_c   = COEF_W'(rnd_c >>> SHIFT);
        pix_sum_c = $signed({{(ACC_W-PIX_W){1'b0}}, pred_q[idx_q]}) + ACC_W'(resid_c);
        if (pix_sum_c < 32'sd0) begin
            pixel_c = '0;
        end else if (pix_sum_c > 32'sd255) begin
            pixel_c = '1;
        end else begin
            pixel_c = PIX_W'(pix_sum_c);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        qp_per_d    = qp_per_q;
        qp_rem_d    = qp_rem_q;
        out_valid_d = 1'b0;
        out_pixel_d = '0;
        out_resid_d = '0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == '0) begin
                        qp_per_d = 3'(QP / 5'd6);
                        qp_rem_d = 3'(QP % 5'd6);
                    end
                    state_d = (idx_q == IDX_W'(BLK_SIZE - 1)) ? S_ROW : S_LOAD;
                end
            end
            S_ROW: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(3)) state_d = S_COL;
            end
            S_COL: begin
                if (idx_q == IDX_W'(7)) begin
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                out_pixel_d = pixel_c;
                out_resid_d = resid_c;
                idx_d       = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(BLK_SIZE - 1)) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            qp_per_q    <= '0;
            qp_rem_q    <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_resid_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            qp_per_q    <= qp_per_d;
            qp_rem_q    <= qp_rem_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_resid_q <= out_resid_d;
        end
    end

    // Data buffers and the working matrix carry no reset; the FSM governs their validity.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            coef_q[idx_q] <= in_coef;
            pred_q[idx_q] <= in_pred;
        end
        if (state_q == S_ROW || state_q == S_COL) begin
            for (int j = 0; j < 4; j++) begin
                if (state_q == S_ROW) begin
                    mat_q[{lane_c, 2'(j)}] <= bf_f_c[j];
                end else begin
                    mat_q[{2'(j), lane_c}] <= bf_f_c[j];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_resid = out_resid_q;

endmodule

// File: tb/tb_hlpte_recon.sv
// Directed bench for hlpte_recon: DC and single-coefficient blocks, clipping, gaps,
// back-to-back blocks and reset during output.
module tb_hlpte_recon;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_coef;
    logic [7:0]         in_pred;
    logic [4:0]         qp;
    logic               out_valid;
    logic [7:0]         out_pixel;
    logic signed [15:0] out_resid;

    int n_checks = 0;
    int n_fail   = 0;

    int c  [16];
    int p  [16];
    int er [16];
    int ep [16];

    always #5 clk = ~clk;

    hlpte_recon dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_coef   (in_coef),
        .in_pred   (in_pred),
        .QP        (qp),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_resid (out_resid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Set all coefficients to 0 except one, uniform prediction.
    task automatic setup(input int pos, input int val, input int pred);
        for (int i = 0; i < 16; i++) begin
            c[i] = 0;
            p[i] = pred;
        end
        c[pos] = val;
    endtask

    task automatic expect_uniform(input int res, input int pix);
        for (int i = 0; i < 16; i++) begin
            er[i] = res;
            ep[i] = pix;
        end
    endtask

    // Called at a negedge; returns at the negedge after the 16th pair's accepting edge.
    task automatic drive_block(input int q, input int gap);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_coef  = 16'(c[i]);
            in_pred  = 8'(p[i]);
            qp       = (i == 0) ? 5'(q) : 5'(q + 1);
            @(negedge clk);
            if (gap > 0 && i < 15) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic monitor(input string tag, input bit junk);
        int rise;
        rise = 0;
        if (junk) begin
            in_valid = 1'b1;
            in_coef  = 16'sh7fff;
            in_pred  = 8'hff;
            qp       = 5'd31;
        end
        for (int k = 1; k <= 20 && rise == 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                rise = k;
            end else begin
                chk({tag, "_idle_pix"}, int'(out_pixel), 0);
                chk({tag, "_idle_res"}, int'(out_resid), 0);
            end
        end
        chk({tag, "_latency"}, rise, 9);
        if (rise == 0) return;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 12) in_valid = 1'b0;
            chk({tag, "_valid"}, int'(out_valid), 1);
            chk({tag, "_res"}, int'(out_resid), er[i]);
            chk({tag, "_pix"}, int'(out_pixel), ep[i]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_fall"}, int'(out_valid), 0);
        chk({tag, "_fall_pix"}, int'(out_pixel), 0);
        chk({tag, "_fall_res"}, int'(out_resid), 0);
    endtask

    initial begin
        int seen;
        int tab_c [4];
        int tab_b [16];

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_coef  = '0;
        in_pred  = '0;
        qp       = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_pix", int'(out_pixel), 0);
        chk("rst_res", int'(out_resid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        setup(0, 0, 128);
        expect_uniform(0, 128);
        drive_block(7, 0);
        monitor("zero", 1'b0);

        setup(0, 64, 100);
        expect_uniform(10, 110);
        drive_block(0, 0);
        monitor("dc64", 1'b1);

        setup(0, 2000, 200);
        expect_uniform(1250, 255);
        drive_block(12, 0);
        monitor("clip_hi", 1'b0);

        setup(0, -64, 5);
        expect_uniform(-10, 0);
        drive_block(0, 0);
        monitor("clip_lo", 1'b1);

        // Odd-odd coefficient at (1,1): class b scale, exercises both passes and floor rounding.
        tab_b = '{16, 8, -8, -16, 8, 4, -4, -8, -8, -4, 4, 8, -16, -8, 8, 16};
        setup(5, 64, 128);
        for (int i = 0; i < 16; i++) begin
            er[i] = tab_b[i];
            ep[i] = 128 + tab_b[i];
        end
        drive_block(0, 0);
        monitor("cls_b", 1'b1);

        // Mixed-parity coefficient at (0,1): class c scale, constant down each column.
        tab_c = '{13, 7, -6, -13};
        setup(1, 64, 100);
        for (int i = 0; i < 16; i++) begin
            er[i] = tab_c[i % 4];
            ep[i] = 100 + tab_c[i % 4];
        end
        drive_block(0, 0);
        monitor("cls_c", 1'b0);

        setup(0, 64, 100);
        expect_uniform(10, 110);
        drive_block(0, 3);
        monitor("gaps", 1'b0);

        setup(0, 2000, 200);
        expect_uniform(1250, 255);
        drive_block(12, 0);
        monitor("b2b", 1'b0);

        // Reset in the middle of the output phase.
        setup(0, -64, 5);
        drive_block(0, 0);
        seen = 0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("abort_started", int'(out_valid), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_pix", int'(out_pixel), 0);
        chk("abort_res", int'(out_resid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_partial", seen, 0);

        setup(0, 64, 100);
        expect_uniform(10, 110);
        drive_block(0, 0);
        monitor("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
